// File: rtl/piano_voice_gen.sv
// Single-voice key-driven tone generator: synchronised keys select a note, a two-stage divider
// makes the square wave, and an attack/sustain/release envelope gates it through a PWM compare.
module piano_voice_gen #(
  parameter int unsigned           NUM_KEYS = 7,
  parameter logic [9*NUM_KEYS-1:0] NOTE_DIV = {9'd61, 9'd55, 9'd48, 9'd43, 9'd41, 9'd36, 9'd32},
  parameter int unsigned           VOL_BITS = 6,
  parameter int unsigned           ENV_STEP = 4096,
  parameter logic                  GAIN_SEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [2:0]          octave,
  input  logic [VOL_BITS-1:0] volume,
  output logic                AIN,
  output logic                GAIN,
  output logic                NC,
  output logic                ACTIVE,
  output logic [3:0]          note_idx
);

  localparam int unsigned EnvW = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
  localparam logic [EnvW-1:0] EnvLoad = EnvW'(ENV_STEP - 1);

  typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} state_e;

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] key_meta_q, key_sync_q;
  logic [3:0]          cur_note_q, cur_note_d;
  logic [2:0]          cur_oct_q, cur_oct_d;
  logic [8:0]          note_cnt_q, note_cnt_d;
  logic [7:0]          oct_cnt_q, oct_cnt_d;
  logic [EnvW-1:0]     env_cnt_q, env_cnt_d;
  logic [VOL_BITS-1:0] level_q, level_d;
  logic                speaker_q, speaker_d;
  logic [VOL_BITS-1:0] pwm_cnt_q;

  logic       any_key;
  logic [3:0] sel;
  logic [2:0] oct_clamp;
  logic       env_tick;

  function automatic logic [8:0] note_div(input logic [3:0] idx);
    logic [8:0] d;
    d = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (idx == 4'(i)) d = NOTE_DIV[9*i +: 9];
    end
    return d;
  endfunction

  function automatic logic [7:0] oct_pre(input logic [2:0] o);
    return 8'hFF >> o;
  endfunction

  always_comb begin
    any_key = |key_sync_q;
    sel     = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (key_sync_q[i]) sel = 4'(i);
    end
    oct_clamp = (octave > 3'd5) ? 3'd5 : octave;
  end

  assign env_tick = (env_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cur_note_d = cur_note_q;
    cur_oct_d  = cur_oct_q;
    note_cnt_d = note_cnt_q;
    oct_cnt_d  = oct_cnt_q;
    env_cnt_d  = env_cnt_q;
    level_d    = level_q;
    speaker_d  = speaker_q;

    if (state_q == StIdle) begin
      note_cnt_d = '0;
      oct_cnt_d  = '0;
      env_cnt_d  = '0;
      speaker_d  = 1'b0;
      if (any_key) begin
        state_d    = StAttack;
        cur_note_d = sel;
        cur_oct_d  = oct_clamp;
        note_cnt_d = note_div(sel);
        oct_cnt_d  = oct_pre(oct_clamp);
        env_cnt_d  = EnvLoad;
      end
    end else begin
      env_cnt_d = env_tick ? EnvLoad : env_cnt_q - EnvW'(1);

      if (note_cnt_q == '0) begin
        if (oct_cnt_q == '0) begin
          // Pitch changes are taken only at a toggle so the waveform stays phase-continuous.
          speaker_d = ~speaker_q;
          if (any_key) begin
            cur_note_d = sel;
            cur_oct_d  = oct_clamp;
          end
          note_cnt_d = note_div(cur_note_d);
          oct_cnt_d  = oct_pre(cur_oct_d);
        end else begin
          note_cnt_d = note_div(cur_note_q);
          oct_cnt_d  = oct_cnt_q - 8'd1;
        end
      end else begin
        note_cnt_d = note_cnt_q - 9'd1;
      end

      case (state_q)
        StAttack: begin
          if (!any_key) begin
            state_d = StRelease;
          end else if (level_q >= volume) begin
            level_d = volume;
            state_d = StSustain;
          end else if (env_tick) begin
            level_d = level_q + VOL_BITS'(1);
          end
        end
        StSustain: begin
          if (!any_key) state_d = StRelease;
          else          level_d = volume;
        end
        StRelease: begin
          if (env_tick && (level_q != '0)) level_d = level_q - VOL_BITS'(1);
          if (any_key) begin
            state_d = StAttack;
          end else if (level_d == '0) begin
            state_d    = StIdle;
            speaker_d  = 1'b0;
            note_cnt_d = '0;
            oct_cnt_d  = '0;
            env_cnt_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      key_meta_q <= '0;
      key_sync_q <= '0;
      cur_note_q <= '0;
      cur_oct_q  <= '0;
      note_cnt_q <= '0;
      oct_cnt_q  <= '0;
      env_cnt_q  <= '0;
      level_q    <= '0;
      speaker_q  <= 1'b0;
      pwm_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_meta_q <= keys;
      key_sync_q <= key_meta_q;
      cur_note_q <= cur_note_d;
      cur_oct_q  <= cur_oct_d;
      note_cnt_q <= note_cnt_d;
      oct_cnt_q  <= oct_cnt_d;
      env_cnt_q  <= env_cnt_d;
      level_q    <= level_d;
      speaker_q  <= speaker_d;
      pwm_cnt_q  <= pwm_cnt_q + VOL_BITS'(1);
    end
  end

  // Combinational from registers so an asynchronous reset mutes the amplifier at once.
  assign AIN      = speaker_q & (pwm_cnt_q < level_q);
  assign GAIN     = GAIN_SEL;
  assign NC       = 1'b0;
  assign ACTIVE   = (state_q != StIdle);
  assign note_idx = cur_note_q;

endmodule
